memory_controller: RTL
======================

# memory_controller

Sequencing controller for the cache's entry storage: a bank of `NUM_ENTRIES` `dynamic_register_array` instances of width `KEY_WIDTH+VALUE_WIDTH`, instantiated by the parent and driven by this block. It accepts one GET/PUT/DEL request at a time over a valid/ready handshake. It resolves key hits and free slots against per-entry valid bits it owns, and drives the one-hot write enables plus a shared write-data bus. It returns status and read data over a second valid/ready handshake.

## Interface
- `NUM_ENTRIES`, 8, number of storage entries (≥2)
- `KEY_WIDTH`, 16, key bits
- `VALUE_WIDTH`, 32, value bits
- Entry word `W = KEY_WIDTH+VALUE_WIDTH`, key in the upper `KEY_WIDTH` bits

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: controller can accept a request
- `req_op` in 2: NOP=0, GET=1, PUT=2, DEL=3
- `req_key` in KEY_WIDTH: request key
- `req_value` in VALUE_WIDTH: PUT value
- `resp_valid` out 1: response present
- `resp_ready` in 1: consumer accepts the response
- `resp_status` out 2: OK=0, MISS=1, FULL=2
- `resp_value` out VALUE_WIDTH: GET data; 0 otherwise
- `entry_write_op` out NUM_ENTRIES: one-hot write enable to the entry arrays
- `entry_select_op` out NUM_ENTRIES: one-hot of the entry addressed by the current operation
- `entry_wdata` out W: shared write data `{key,value}`
- `entry_rdata` in NUM_ENTRIES*W: concatenated entry outputs; entry i at `[i*W +: W]`
- `occupancy` out $clog2(NUM_ENTRIES+1): count of valid entries

## Operation
- FSM states: IDLE, LOOKUP, COMMIT, RESP.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid&&req_ready`, latch op/key/value and go to LOOKUP.
  - A NOP is accepted and answered with OK, with no entry activity.
- **LOOKUP**
  - Compute `hit_vec = valid & (entry key == latched key)`, `hit_idx` = lowest set bit of `hit_vec`, `free_idx` = lowest set bit of `~valid`.
  - Register the outcome; go to COMMIT.
- **COMMIT** (actions per op):
  - GET hit: capture the entry value into `resp_value`, status OK.
  - GET miss: status MISS, `resp_value=0`.
  - PUT hit: `entry_write_op[hit_idx]=1`, overwriting in place; status OK; valid unchanged.
  - PUT miss with a free slot: `entry_write_op[free_idx]=1`, set that valid bit, status OK.
  - PUT miss, all valid: no write, status FULL.
  - DEL hit: clear `valid[hit_idx]`, status OK; entry contents untouched.
  - DEL miss: status MISS.
  - Then go to RESP.
- **RESP**
  - `resp_valid=1`; outputs are held stable until `resp_ready`.
  - On handshake, go to IDLE.
- `entry_select_op` is the one-hot of the hit or allocated index during COMMIT and RESP, and 0 otherwise.
- `entry_wdata` is driven from the latched key/value at all times.
- `entry_write_op` is high for exactly one COMMIT cycle and never has more than one bit set.
- `occupancy` equals popcount(valid). It is registered and updated together with the valid bits.
- Keys are unique by construction: PUT always checks for a hit before allocating.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - State IDLE, all valid bits 0.
  - Outputs: `req_ready=1`, `resp_valid=0`, `resp_status=0`, `resp_value=0`, `entry_write_op=0`, `entry_select_op=0`, `occupancy=0`, latched key/value 0.
  - Reset mid-operation aborts it. Any write that was not yet committed does not happen, and no response is produced.
- Latency, counting the request handshake as edge 0:
  - LOOKUP occupies the cycle after edge 0.
  - COMMIT occupies the cycle after edge 1.
  - `resp_valid` rises after edge 2.
  - The entry register updates on edge 2, the write edge. A following GET therefore sees the new data.
- Throughput: one request per 4 cycles when `resp_ready` is held high.
- `req_ready=0` in LOOKUP, COMMIT and RESP. No request is accepted while a response is pending, including in the cycle of the response handshake.
- `entry_rdata` is sampled only in LOOKUP and COMMIT.

## Structure
- Package `memory_pkg` holds:
  - `op_e`
  - `status_e`
  - `state_e`
  - Widths derived for the occupancy and index fields
- Sub-module `lowest_set_index #(N)`: combinational priority encoder returning the index plus a found flag. It is instantiated twice, once for hits and once for free slots.
- Valid bits, counters and FSM live in the controller. The parent instantiates the `NUM_ENTRIES` entry arrays and wires `entry_write_op[i]` to `write_op`, `entry_select_op[i]` to `select_op`, and `entry_wdata` to every `data_in`.

## Test plan
- **Reset, then PUT:** after reset, PUT key 0x0011 value 0xDEADBEEF → `entry_write_op=8'b0000_0001` for exactly one cycle, status OK, `occupancy=1`. A following GET 0x0011 returns OK with 0xDEADBEEF.
- **GET and DEL on a missing key:** GET 0x0022 on an empty store → MISS, value 0. DEL 0x0022 → MISS, `occupancy` unchanged.
- **Overwrite:** PUT 0x0011 value 0x1, then PUT 0x0011 value 0x2 → second write hits entry 0, `occupancy` stays 1, GET returns 0x2.
- **Full store and slot reuse:**
  - Fill 8 distinct keys; a 9th PUT returns FULL with no `entry_write_op`.
  - DEL the key in entry 3, then PUT a new key → written to entry 3, `occupancy=8`.
- **Back-pressure and mid-operation reset:**
  - Hold `resp_ready=0` for 5 cycles in RESP → `resp_valid`, status and value stay stable, and `req_ready` stays 0.
  - Assert `rst_n=0` during COMMIT of a PUT → no write occurs, `occupancy=0`, and the FSM is in IDLE.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and width helpers for the cache entry-storage controller.
package memory_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_GET = 2'd1,
    OP_PUT = 2'd2,
    OP_DEL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Width of a 0..n population count.
  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index into n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus a found flag.
module lowest_set_index
  import memory_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]          vec,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = idx_w(N)'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Sequencer for the cache entry bank: one GET/PUT/DEL at a time, IDLE->LOOKUP->COMMIT->RESP.
module memory_controller
  import memory_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [1:0]                                   req_op,
  input  logic [KEY_WIDTH-1:0]                         req_key,
  input  logic [VALUE_WIDTH-1:0]                       req_value,
  output logic                                         resp_valid,
  input  logic                                         resp_ready,
  output logic [1:0]                                   resp_status,
  output logic [VALUE_WIDTH-1:0]                       resp_value,
  output logic [NUM_ENTRIES-1:0]                       entry_write_op,
  output logic [NUM_ENTRIES-1:0]                       entry_select_op,
  output logic [KEY_WIDTH+VALUE_WIDTH-1:0]             entry_wdata,
  input  logic [NUM_ENTRIES*(KEY_WIDTH+VALUE_WIDTH)-1:0] entry_rdata,
  output logic [occ_w(NUM_ENTRIES)-1:0]                occupancy
);

  localparam int W  = KEY_WIDTH + VALUE_WIDTH;
  localparam int OW = occ_w(NUM_ENTRIES);
  localparam int IW = idx_w(NUM_ENTRIES);

  state_e                           state_q, state_d;
  op_e                              op_q;
  logic [KEY_WIDTH-1:0]             key_q;
  logic [VALUE_WIDTH-1:0]           val_q;
  logic [NUM_ENTRIES-1:0]           valid_q;
  logic [OW-1:0]                    occ_q;
  logic                             hit_q, free_q;
  logic [IW-1:0]                    hit_idx_q, free_idx_q;
  status_e                          status_q;
  logic [VALUE_WIDTH-1:0]           rvalue_q;

  logic [NUM_ENTRIES-1:0][W-1:0]    ent;
  logic [NUM_ENTRIES-1:0]           hit_vec;
  logic [IW-1:0]                    hit_idx, free_idx;
  logic                             hit_found, free_found;
  logic                             do_alloc, tgt_en;
  logic [IW-1:0]                    tgt_idx;
  logic [NUM_ENTRIES-1:0]           tgt_oh;

  assign ent = entry_rdata;

  // Per-entry key match, qualified by the valid bits owned here.
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_match
    assign hit_vec[i] = valid_q[i] && (ent[i][W-1 -: KEY_WIDTH] == key_q);
  end

  lowest_set_index #(.N(NUM_ENTRIES)) u_hit (
    .vec(hit_vec), .idx(hit_idx), .found(hit_found)
  );

  lowest_set_index #(.N(NUM_ENTRIES)) u_free (
    .vec(~valid_q), .idx(free_idx), .found(free_found)
  );

  // Entry addressed by the current op, from the registered lookup outcome.
  assign do_alloc = (op_q == OP_PUT) && !hit_q && free_q;
  assign tgt_en   = ((op_q != OP_NOP) && hit_q) || do_alloc;
  assign tgt_idx  = hit_q ? hit_idx_q : free_idx_q;
  assign tgt_oh   = tgt_en ? (NUM_ENTRIES'(1) << tgt_idx) : '0;

  assign entry_wdata = {key_q, val_q};
  assign resp_status = status_q;
  assign resp_value  = rvalue_q;
  assign occupancy   = occ_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    entry_write_op  = '0;
    entry_select_op = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_COMMIT;
      S_COMMIT: begin
        entry_select_op = tgt_oh;
        if (op_q == OP_PUT) entry_write_op = tgt_oh;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid      = 1'b1;
        entry_select_op = tgt_oh;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, lookup capture, and commit of valid bits / response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOP;
      key_q      <= '0;
      val_q      <= '0;
      valid_q    <= '0;
      occ_q      <= '0;
      hit_q      <= 1'b0;
      free_q     <= 1'b0;
      hit_idx_q  <= '0;
      free_idx_q <= '0;
      status_q   <= ST_OK;
      rvalue_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q  <= op_e'(req_op);
          key_q <= req_key;
          val_q <= req_value;
        end
        S_LOOKUP: begin
          hit_q      <= hit_found;
          hit_idx_q  <= hit_idx;
          free_q     <= free_found;
          free_idx_q <= free_idx;
        end
        S_COMMIT: begin
          rvalue_q <= '0;
          status_q <= ST_OK;
          case (op_q)
            OP_GET: begin
              if (hit_q) rvalue_q <= ent[hit_idx_q][VALUE_WIDTH-1:0];
              else       status_q <= ST_MISS;
            end
            OP_PUT: begin
              if (do_alloc) begin
                valid_q[free_idx_q] <= 1'b1;
                occ_q               <= occ_q + OW'(1);
              end else if (!hit_q) begin
                status_q <= ST_FULL;
              end
            end
            OP_DEL: begin
              if (hit_q) begin
                valid_q[hit_idx_q] <= 1'b0;
                occ_q              <= occ_q - OW'(1);
              end else begin
                status_q <= ST_MISS;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
